serial_magnitude_comparator: RTL
================================

// Module: serial_magnitude_comparator
// PURPOSE
//   Bit-serial magnitude comparator: consumes two WIDTH-bit operands one bit pair per beat,
//   LSB first, over a valid/ready stream and reports eq/gt/lt once the word completes.
//   Counterpart to the parallel comparators: it serves links where operands arrive serialised
//   (shift-register or UART-style paths). Result is registered and flagged by a 1-cycle pulse.
// PARAMETERS
//   WIDTH  4  operand width in bits; legal range 2..64; defines beats per word
// PORTS
//   clk        in   1  single clock, all state on rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  bit pair on in_a/in_b valid this cycle
//   in_ready   out  1  block accepts a bit pair this cycle
//   in_a       in   1  current bit of operand a (LSB first)
//   in_b       in   1  current bit of operand b (LSB first)
//   abort      in   1  synchronous: discard partial word, return to IDLE
//   res_valid  out  1  1-cycle pulse: eq/gt/lt updated with a new result
//   eq         out  1  a == b (held until next result)
//   gt         out  1  a >  b (held)
//   lt         out  1  a <  b (held)
// BEHAVIOUR
//   - Reset: state=IDLE, bit count=0, running relation=EQ, in_ready=1, res_valid=0, eq=gt=lt=0.
//   - Beat accepted when in_valid && in_ready. No beat -> nothing changes (gaps allowed anywhere).
//   - FSM: IDLE -(beat)-> RUN; RUN -(beat with count==WIDTH-1)-> DONE; DONE -> IDLE (always,
//     1 cycle). WIDTH beats per word; the first beat in IDLE is bit 0 and loads count=1.
//   - in_ready = 1 in IDLE and RUN, 0 in DONE (one bubble per word).
//   - Relation update per beat (LSB first, later bits dominate): in_a!=in_b -> rel = in_a ? GT : LT;
//     in_a==in_b -> rel unchanged. First beat of a word starts from rel=EQ, ignoring leftovers.
//   - Last beat: final relation (including that beat) registered into eq/gt/lt in the DONE
//     cycle; res_valid=1 exactly in DONE. Latency: result visible 1 cycle after last beat.
//   - Exactly one of eq/gt/lt is 1 after the first result; all three 0 only before it.
//   - abort: highest priority after reset; in any state -> IDLE, count=0, rel=EQ; beat in the
//     same cycle is dropped; eq/gt/lt keep the previous result; a pending DONE pulse is suppressed.
//   - Async reset mid-word: word lost, all outputs to reset values immediately.
//   - Counter width $clog2(WIDTH); no wrap beyond WIDTH-1 (DONE always intervenes).
// CONFIGURATION
//   SERIAL_CMP_SIGNED_EN defined: operands are two's complement; on the last beat (sign bit),
//     differing bits give rel = in_a ? LT : GT (inverted); equal sign bits keep the running rel.
//   Not defined: unsigned comparison, last beat handled like every other beat.
// STRUCTURE
//   Package cmp_pkg: typedef enum rel_t {REL_EQ, REL_GT, REL_LT}; typedef enum state_t
//     {ST_IDLE, ST_RUN, ST_DONE}; function rel_to_flags(rel_t) -> {eq,gt,lt}.
//   Sub-module cmp_bit_cell (combinational): inputs rel_in, a, b, is_msb -> rel_out;
//     holds the update rule and the SIGNED_EN sign-bit inversion. Top holds FSM, counter, regs.
// TESTING (WIDTH=4, unless noted)
//   1 a=10,b=6: beats (a,b) LSB first (0,0)(1,1)(0,1)(1,0) -> next cycle res_valid=1, gt=1.
//   2 a=5,b=5 with in_valid low 2 cycles between each beat -> res_valid once, eq=1; in_ready=0
//     only in the DONE cycle.
//   3 back-to-back words a=3,b=12 then a=12,b=3, in_valid held high -> lt=1 then gt=1; one
//     bubble (in_ready=0) between words, no beat lost.
//   4 abort after 2 beats of a=15,b=0, then word a=0,b=1 -> no pulse for aborted word;
//     next result lt=1; eq/gt/lt unchanged during abort.
//   5 rst_n low mid-word (after 3 beats) -> eq=gt=lt=res_valid=0 asynchronously, in_ready=1
//     after release; next full word compares correctly.
//   6 SERIAL_CMP_SIGNED_EN: a=4'b1010(-6), b=4'b0110(6) -> lt=1; without macro same stimulus -> gt=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared relation/state types and flag decoding for the serial comparator
package cmp_pkg;

    typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} rel_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    // Returns {eq, gt, lt}
    function automatic logic [2:0] rel_to_flags(input rel_t r);
        return {r == REL_EQ, r == REL_GT, r == REL_LT};
    endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// cmp_bit_cell: one LSB-first update step of the running relation (SERIAL_CMP_SIGNED_EN inverts the sign bit)
import cmp_pkg::*;

module cmp_bit_cell (
    input  rel_t rel_in,
    input  logic a,
    input  logic b,
    input  logic is_msb,
    output rel_t rel_out
);

`ifdef SERIAL_CMP_SIGNED_EN
    localparam logic SIGNED = 1'b1;
`else
    localparam logic SIGNED = 1'b0;
`endif

    // A set sign bit means a smaller value in two's complement, so the winner flips there
    assign rel_out = (a == b) ? rel_in : ((a ^ (is_msb & SIGNED)) ? REL_GT : REL_LT);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: LSB-first bit-serial eq/gt/lt comparator (SERIAL_CMP_SIGNED_EN selects signed)
import cmp_pkg::*;

module serial_magnitude_comparator #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_a,
    input  logic in_b,
    input  logic abort,
    output logic res_valid,
    output logic eq,
    output logic gt,
    output logic lt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_n;
    rel_t rel, rel_n, rel_cell_in, rel_cell_out;
    logic [CW-1:0] cnt, cnt_n;
    logic beat, load;

    assign in_ready = state != ST_DONE;
    assign res_valid = state == ST_DONE;
    assign beat = in_valid && in_ready;
    assign rel_cell_in = (state == ST_IDLE) ? REL_EQ : rel;

    cmp_bit_cell u_cell (
        .rel_in (rel_cell_in),
        .a      (in_a),
        .b      (in_b),
        .is_msb (cnt == LAST),
        .rel_out(rel_cell_out)
    );

    // Next state: abort overrides everything, otherwise advance on each accepted beat
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        rel_n = rel;
        load = 1'b0;
        if (abort) begin
            state_n = ST_IDLE;
            cnt_n = '0;
            rel_n = REL_EQ;
        end else begin
            case (state)
                ST_IDLE: if (beat) begin
                    state_n = ST_RUN;
                    cnt_n = CW'(1);
                    rel_n = rel_cell_out;
                end
                ST_RUN: if (beat) begin
                    rel_n = rel_cell_out;
                    if (cnt == LAST) begin
                        state_n = ST_DONE;
                        cnt_n = '0;
                        load = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State, counter, running relation and held result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt <= '0;
            rel <= REL_EQ;
            {eq, gt, lt} <= 3'b000;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            rel <= rel_n;
            if (load) {eq, gt, lt} <= rel_to_flags(rel_cell_out);
        end
    end

endmodule
